// File: rtl/calc_bank_if.sv
// calc_bank_if: button/switch/LED bundle for the calc_bank accumulator unit.
// master drives the buttons, operand and index; slave (the bank) drives the
// LED view and the status flags.
interface calc_bank_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) ();
  localparam int SW = $clog2(DEPTH);

  logic             btnl;
  logic             btnc;
  logic             btnr;
  logic             btnd;
  logic             btnu;
  logic [WIDTH-1:0] sw;
  logic [SW-1:0]    sel;
  logic [WIDTH-1:0] led;
  logic             busy;
  logic             ovf;

  modport master (
    output btnl, btnc, btnr, btnd, btnu, sw, sel,
    input  led, busy, ovf
  );

  modport slave (
    input  btnl, btnc, btnr, btnd, btnu, sw, sel,
    output led, busy, ovf
  );
endinterface

// File: rtl/calc_bank.sv
// calc_bank: a bank of DEPTH signed accumulators driven by push buttons.
// btnd starts a three-state execute (IDLE -> EXEC -> WRITE) that applies
// op = {btnl,btnc,btnr} to accumulator[sel] with operand sw; btnu clears
// accumulator[sel]. Both buttons act on rising edges only, and edges seen
// while an execute is in flight are dropped.
// Optional feature: define CALC_BANK_UNDO_EN to add one shadow register per
// accumulator; a btnu edge while btnd is held then restores the value the
// accumulator had before its last write or clear.
module calc_bank #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  calc_bank_if.slave bus
);
  localparam int SW  = $clog2(DEPTH);
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    WRITE = 2'd2
  } state_t;

  // Modulo-2^WIDTH ALU; shift amount is the low log2(WIDTH) bits of b.
  function automatic logic signed [WIDTH-1:0] alu_res(
    input logic [2:0]              op,
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      3'b000:  alu_res = a & b;
      3'b001:  alu_res = a | b;
      3'b010:  alu_res = a + b;
      3'b011:  alu_res = a - b;
      3'b100:  alu_res = a ^ b;
      3'b101:  alu_res = a << sh;
      3'b110:  alu_res = a >> sh;
      default: alu_res = a >>> sh;
    endcase
  endfunction

  // Signed overflow of ADD/SUB from operand and result sign bits; every
  // other op reports no overflow.
  function automatic logic alu_ovf(
    input logic [2:0]              op,
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b,
    input logic signed [WIDTH-1:0] r
  );
    case (op)
      3'b010:  alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      3'b011:  alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      default: alu_ovf = 1'b0;
    endcase
  endfunction

  state_t                  state;
  logic                    busy_r;
  logic                    ovf_r;
  logic                    prev_d;
  logic                    prev_u;

  logic [2:0]              op_p0;
  logic signed [WIDTH-1:0] b_p0;
  logic [SW-1:0]           sel_p0;

  logic signed [WIDTH-1:0] res_p1;
  logic                    ovf_p1;

  logic signed [WIDTH-1:0] acc [DEPTH];

  logic                    d_edge;
  logic                    u_edge;
  logic                    clr_fire;
  logic                    exe_fire;
  logic signed [WIDTH-1:0] a_sel;
  logic signed [WIDTH-1:0] res_c;
  logic                    ovf_c;
  logic signed [WIDTH-1:0] restore_val;

  assign d_edge   = bus.btnd & ~prev_d;
  assign u_edge   = bus.btnu & ~prev_u;
  assign clr_fire = (state == IDLE) & u_edge;
  // A clear edge takes priority over a simultaneous execute edge.
  assign exe_fire = (state == IDLE) & d_edge & ~u_edge;

  assign a_sel = acc[sel_p0];
  assign res_c = alu_res(op_p0, a_sel, b_p0);
  assign ovf_c = alu_ovf(op_p0, a_sel, b_p0, res_c);

`ifdef CALC_BANK_UNDO_EN
  logic signed [WIDTH-1:0] shadow [DEPTH];
  logic                    undo_fire;
  logic                    wr_fire;

  // Holding btnd turns a clear into an undo from the shadow copy.
  assign undo_fire   = clr_fire & bus.btnd;
  assign wr_fire     = (state == WRITE);
  assign restore_val = undo_fire ? shadow[bus.sel] : '0;

  // Shadow keeps the pre-write value of each accumulator; an undo leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) shadow[i] <= '0;
    end else if (clr_fire && !undo_fire) begin
      shadow[bus.sel] <= acc[bus.sel];
    end else if (wr_fire) begin
      shadow[sel_p0] <= acc[sel_p0];
    end
  end
`else
  assign restore_val = '0;
`endif

  assign bus.led  = acc[bus.sel];
  assign bus.busy = busy_r;
  assign bus.ovf  = ovf_r;

  // Button history for rising-edge detection; runs every cycle, busy or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_d <= 1'b0;
      prev_u <= 1'b0;
    end else begin
      prev_d <= bus.btnd;
      prev_u <= bus.btnu;
    end
  end

  // Control FSM with operand capture, ALU result register and bank writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      ovf_r  <= 1'b0;
      op_p0  <= '0;
      b_p0   <= '0;
      sel_p0 <= '0;
      res_p1 <= '0;
      ovf_p1 <= 1'b0;
      for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
    end else begin
      case (state)
        // p0: operands frozen at the execute edge
        IDLE: begin
          if (clr_fire) begin
            acc[bus.sel] <= restore_val;
            ovf_r        <= 1'b0;
          end else if (exe_fire) begin
            op_p0  <= {bus.btnl, bus.btnc, bus.btnr};
            b_p0   <= $signed(bus.sw);
            sel_p0 <= bus.sel;
            state  <= EXEC;
            busy_r <= 1'b1;
          end
        end
        // p1: ALU result and overflow registered
        EXEC: begin
          res_p1 <= res_c;
          ovf_p1 <= ovf_c;
          state  <= WRITE;
        end
        // p2: result committed to the bank
        WRITE: begin
          acc[sel_p0] <= res_p1;
          ovf_r       <= ovf_p1;
          state       <= IDLE;
          busy_r      <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end
endmodule
